// File: rtl/aha_platform_ctrl_pkg.sv
// Shared platform-control definitions: sequencer FSM encoding, default
// timing parameters and the peripheral index map.
package aha_platform_ctrl_pkg;

  // Sequencer FSM encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GATE    = 2'd1;
  localparam logic [1:0] ST_ASSERT  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Default sequencing parameters.
  localparam int NUM_PERIPH_DEF = 11;
  localparam int GATE_CYC_DEF   = 2;
  localparam int HOLD_CYC_DEF   = 4;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int CNT_W_DEF      = 8;

  // Peripheral index map.
  localparam int P_DMA0    = 0;
  localparam int P_DMA1    = 1;
  localparam int P_TLX_FWD = 2;
  localparam int P_TLX_REV = 3;
  localparam int P_CGRA    = 4;
  localparam int P_NIC     = 5;
  localparam int P_TIMER0  = 6;
  localparam int P_TIMER1  = 7;
  localparam int P_UART0   = 8;
  localparam int P_UART1   = 9;
  localparam int P_WDOG    = 10;

endpackage

// File: rtl/aha_periph_reset_sequencer_if.sv
// Register-space / clock-reset-generation side signals of the soft-reset
// sequencer. master = register space, slave = sequencer.
interface aha_periph_reset_sequencer_if
  import aha_platform_ctrl_pkg::*;
#(
  parameter int NUM_PERIPH = NUM_PERIPH_DEF,
  parameter int IDX_W      = $clog2(NUM_PERIPH)
);
  logic [NUM_PERIPH-1:0] RESET_REQ;
  logic [NUM_PERIPH-1:0] CLK_GATE_EN;
  logic [NUM_PERIPH-1:0] RESET_ACK;
  logic [NUM_PERIPH-1:0] PERIPH_RESETn;
  logic [NUM_PERIPH-1:0] PERIPH_CLK_EN;
  logic                  BUSY;
  logic [IDX_W-1:0]      CUR_IDX;

  modport master (
    output RESET_REQ, CLK_GATE_EN,
    input  RESET_ACK, PERIPH_RESETn, PERIPH_CLK_EN, BUSY, CUR_IDX
  );

  modport slave (
    input  RESET_REQ, CLK_GATE_EN,
    output RESET_ACK, PERIPH_RESETn, PERIPH_CLK_EN, BUSY, CUR_IDX
  );
endinterface

// File: rtl/aha_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or
// after ptr, searching cyclically.
module aha_rr_arbiter #(
  parameter int N     = 11,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // Walk from the farthest offset back to ptr so the nearest request wins.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/aha_periph_reset_sequencer.sv
// Per-peripheral soft-reset sequencer: arbitrates pending RESET_REQ bits
// round-robin and, for the granted peripheral, gates its clock, pulses its
// reset, waits for it to settle, ungates the clock and raises RESET_ACK.
module aha_periph_reset_sequencer
  import aha_platform_ctrl_pkg::*;
#(
  parameter int NUM_PERIPH = NUM_PERIPH_DEF,
  parameter int GATE_CYC   = GATE_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic                         HCLK,
  input logic                         HRESETn,
  aha_periph_reset_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_PERIPH);
  localparam logic [NUM_PERIPH-1:0] ONE = NUM_PERIPH'(1);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      idx_d;
  logic                  seq_done;
  logic [NUM_PERIPH-1:0] pending;
  logic                  gnt_valid;
  logic [IDX_W-1:0]      gnt_idx;
  logic [NUM_PERIPH-1:0] gate_mask_d, rst_mask_d, cur_mask, ack_d;

  // An acknowledged request stays out of arbitration until software drops it.
  assign pending = bus.RESET_REQ & ~bus.RESET_ACK;

  aha_rr_arbiter #(.N(NUM_PERIPH), .IDX_W(IDX_W)) u_arb (
    .req       (pending),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Next-state logic: FSM, phase counter, round-robin pointer, serviced index.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = bus.CUR_IDX;
    seq_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d  = ST_GATE;
          cnt_d    = CNT_W'(GATE_CYC - 1);
          idx_d    = gnt_idx;
          rr_ptr_d = (gnt_idx == IDX_W'(NUM_PERIPH - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      ST_GATE: begin
        if (cnt_q == '0) begin
          state_d = ST_ASSERT;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          state_d = ST_RELEASE;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          seq_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // Output masks derived from the next state so the registered outputs line
  // up with the phase the FSM is entering.
  always_comb begin
    gate_mask_d = (state_d != ST_IDLE)   ? (ONE << idx_d) : '0;
    rst_mask_d  = (state_d == ST_ASSERT) ? (ONE << idx_d) : '0;
    cur_mask    = ONE << bus.CUR_IDX;
    ack_d       = (bus.RESET_ACK & bus.RESET_REQ)
                | (cur_mask & bus.RESET_REQ & {NUM_PERIPH{seq_done}});
  end

  // State and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      rr_ptr_q          <= '0;
      bus.CUR_IDX       <= '0;
      bus.BUSY          <= 1'b0;
      bus.RESET_ACK     <= '0;
      bus.PERIPH_RESETn <= '1;
      bus.PERIPH_CLK_EN <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      rr_ptr_q          <= rr_ptr_d;
      bus.CUR_IDX       <= idx_d;
      bus.BUSY          <= (state_d != ST_IDLE);
      bus.RESET_ACK     <= ack_d;
      bus.PERIPH_RESETn <= ~rst_mask_d;
      bus.PERIPH_CLK_EN <= bus.CLK_GATE_EN & ~gate_mask_d;
    end
  end

endmodule

// File: tb/tb_aha_periph_reset_sequencer.sv
// Self-checking bench for aha_periph_reset_sequencer. Expected ack order is
// pushed to a scoreboard when requests are driven; a negedge monitor pops it
// whenever a RESET_ACK bit rises.
module tb_aha_periph_reset_sequencer;

  localparam int N = 11;
  localparam logic [N-1:0] ALL1 = '1;

  logic hclk;
  logic hresetn;
  int   checks;
  int   errors;
  int   exp_q[$];
  logic [N-1:0] prev_ack;
  logic [N-1:0] rise;
  int   exp_idx;

  aha_periph_reset_sequencer_if #(.NUM_PERIPH(N)) bus ();

  aha_periph_reset_sequencer #(.NUM_PERIPH(N)) dut (
    .HCLK    (hclk),
    .HRESETn (hresetn),
    .bus     (bus.slave)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Ack-order scoreboard.
  always @(negedge hclk) begin
    rise = bus.RESET_ACK & ~prev_ack;
    for (int i = 0; i < N; i++) begin
      if (rise[i]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ack_order: unexpected ack on index %0d, none expected", i);
        end else begin
          exp_idx = exp_q.pop_front();
          if (exp_idx != i) begin
            errors++;
            $display("FAIL ack_order: got ack %0d expected %0d", i, exp_idx);
          end
        end
      end
    end
    prev_ack = bus.RESET_ACK;
  end

  task automatic wait_ack(input int idx, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge hclk);
      if (bus.RESET_ACK[idx]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: ack %0d not seen within 60 cycles, got 0 expected 1", name, idx);
    end
  endtask

  task automatic test_reset();
    hresetn         = 1'b0;
    bus.RESET_REQ   = '0;
    bus.CLK_GATE_EN = ALL1;
    repeat (3) @(negedge hclk);
    checks++; if (bus.RESET_ACK !== '0) begin errors++; $display("FAIL rst_ack: got %h expected 0", bus.RESET_ACK); end
    checks++; if (bus.PERIPH_RESETn !== ALL1) begin errors++; $display("FAIL rst_resetn: got %h expected %h", bus.PERIPH_RESETn, ALL1); end
    checks++; if (bus.PERIPH_CLK_EN !== '0) begin errors++; $display("FAIL rst_clken: got %h expected 0", bus.PERIPH_CLK_EN); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.BUSY); end
    checks++; if (bus.CUR_IDX !== 4'd0) begin errors++; $display("FAIL rst_idx: got %0d expected 0", bus.CUR_IDX); end
    hresetn = 1'b1;
    @(negedge hclk);
    checks++; if (bus.PERIPH_CLK_EN !== ALL1) begin errors++; $display("FAIL rst_clken_track: got %h expected %h", bus.PERIPH_CLK_EN, ALL1); end
  endtask

  task automatic test_single();
    bus.RESET_REQ[4] = 1'b1;
    exp_q.push_back(4);
    for (int c = 1; c <= 10; c++) begin
      @(negedge hclk);
      checks++; if (bus.PERIPH_CLK_EN[4] !== 1'b0) begin errors++; $display("FAIL single_clken c%0d: got %b expected 0", c, bus.PERIPH_CLK_EN[4]); end
      checks++; if (bus.PERIPH_RESETn[4] !== ((c >= 3 && c <= 6) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL single_resetn c%0d: got %b expected %b", c, bus.PERIPH_RESETn[4], (c >= 3 && c <= 6) ? 1'b0 : 1'b1); end
      checks++; if (bus.BUSY !== 1'b1 || bus.CUR_IDX !== 4'd4) begin errors++; $display("FAIL single_busy c%0d: got busy=%b idx=%0d expected busy=1 idx=4", c, bus.BUSY, bus.CUR_IDX); end
      checks++; if (bus.RESET_ACK[4] !== 1'b0) begin errors++; $display("FAIL single_early_ack c%0d: got 1 expected 0", c); end
    end
    @(negedge hclk);
    checks++; if (bus.RESET_ACK[4] !== 1'b1) begin errors++; $display("FAIL single_ack: got %b expected 1", bus.RESET_ACK[4]); end
    checks++; if (bus.PERIPH_CLK_EN !== ALL1 || bus.BUSY !== 1'b0 || bus.CUR_IDX !== 4'd0) begin errors++; $display("FAIL single_done: got clken=%h busy=%b idx=%0d expected %h 0 0", bus.PERIPH_CLK_EN, bus.BUSY, bus.CUR_IDX, ALL1); end
    bus.RESET_REQ[4] = 1'b0;
    @(negedge hclk);
    checks++; if (bus.RESET_ACK[4] !== 1'b0) begin errors++; $display("FAIL single_ack_clear: got %b expected 0", bus.RESET_ACK[4]); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL single_no_regrant: got busy=%b expected 0", bus.BUSY); end
  endtask

  task automatic test_round_robin();
    bus.RESET_REQ = N'(11'h005);
    exp_q.push_back(0);
    exp_q.push_back(2);
    wait_ack(0, "rr_ack0");
    checks++; if (bus.RESET_ACK[2] !== 1'b0) begin errors++; $display("FAIL rr_order: ack2 got %b expected 0 when ack0 rises", bus.RESET_ACK[2]); end
    wait_ack(2, "rr_ack2");
  endtask

  task automatic test_fairness();
    // Drop 0 and 2 while raising 1: ack clear and grant on the same edge.
    bus.RESET_REQ = N'(11'h002);
    exp_q.push_back(1);
    @(negedge hclk);
    checks++; if (bus.RESET_ACK[0] !== 1'b0 || bus.RESET_ACK[2] !== 1'b0) begin errors++; $display("FAIL fair_ack_clear: got %h expected bits 0,2 clear", bus.RESET_ACK); end
    checks++; if (bus.BUSY !== 1'b1 || bus.CUR_IDX !== 4'd1) begin errors++; $display("FAIL fair_grant1: got busy=%b idx=%0d expected 1 1", bus.BUSY, bus.CUR_IDX); end
    bus.RESET_REQ = N'(11'h007);
    exp_q.push_back(2);
    exp_q.push_back(0);
    wait_ack(1, "fair_ack1");
    wait_ack(2, "fair_ack2");
    wait_ack(0, "fair_ack0");
    bus.RESET_REQ = '0;
    repeat (2) @(negedge hclk);
    checks++; if (bus.RESET_ACK !== '0 || bus.BUSY !== 1'b0) begin errors++; $display("FAIL fair_idle: got ack=%h busy=%b expected 0 0", bus.RESET_ACK, bus.BUSY); end
  endtask

  task automatic test_drop_mid();
    bus.RESET_REQ[3] = 1'b1;
    repeat (3) @(negedge hclk);
    checks++; if (bus.PERIPH_RESETn[3] !== 1'b0 || bus.CUR_IDX !== 4'd3) begin errors++; $display("FAIL drop_assert: got resetn=%b idx=%0d expected 0 3", bus.PERIPH_RESETn[3], bus.CUR_IDX); end
    bus.RESET_REQ[3] = 1'b0;
    repeat (7) @(negedge hclk);
    checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL drop_still_busy: got %b expected 1", bus.BUSY); end
    @(negedge hclk);
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL drop_busy_low: got %b expected 0", bus.BUSY); end
    checks++; if (bus.RESET_ACK[3] !== 1'b0) begin errors++; $display("FAIL drop_no_ack: got %b expected 0", bus.RESET_ACK[3]); end
    checks++; if (bus.PERIPH_RESETn !== ALL1 || bus.PERIPH_CLK_EN !== ALL1) begin errors++; $display("FAIL drop_outputs: got rn=%h ce=%h expected %h %h", bus.PERIPH_RESETn, bus.PERIPH_CLK_EN, ALL1, ALL1); end
  endtask

  task automatic test_async_reset();
    bus.RESET_REQ[7] = 1'b1;
    repeat (4) @(negedge hclk);
    checks++; if (bus.PERIPH_RESETn[7] !== 1'b0 || bus.BUSY !== 1'b1) begin errors++; $display("FAIL arst_pre: got rn7=%b busy=%b expected 0 1", bus.PERIPH_RESETn[7], bus.BUSY); end
    #2 hresetn = 1'b0;
    #1;
    checks++; if (bus.PERIPH_RESETn !== ALL1) begin errors++; $display("FAIL arst_resetn: got %h expected %h", bus.PERIPH_RESETn, ALL1); end
    checks++; if (bus.BUSY !== 1'b0 || bus.CUR_IDX !== 4'd0) begin errors++; $display("FAIL arst_busy: got busy=%b idx=%0d expected 0 0", bus.BUSY, bus.CUR_IDX); end
    checks++; if (bus.PERIPH_CLK_EN !== '0) begin errors++; $display("FAIL arst_clken: got %h expected 0", bus.PERIPH_CLK_EN); end
    @(negedge hclk);
    bus.RESET_REQ = '0;
    hresetn = 1'b1;
    @(negedge hclk);
  endtask

  task automatic test_unserviced();
    bus.CLK_GATE_EN[9] = 1'b0;
    bus.RESET_REQ[1]   = 1'b1;
    exp_q.push_back(1);
    repeat (5) @(negedge hclk);
    checks++; if (bus.CUR_IDX !== 4'd1) begin errors++; $display("FAIL unsvc_idx: got %0d expected 1", bus.CUR_IDX); end
    checks++; if (bus.PERIPH_CLK_EN !== (ALL1 & ~N'(11'h202))) begin errors++; $display("FAIL unsvc_clken_mid: got %h expected %h", bus.PERIPH_CLK_EN, ALL1 & ~N'(11'h202)); end
    wait_ack(1, "unsvc_ack1");
    checks++; if (bus.PERIPH_CLK_EN !== (ALL1 & ~N'(11'h200))) begin errors++; $display("FAIL unsvc_clken_done: got %h expected %h", bus.PERIPH_CLK_EN, ALL1 & ~N'(11'h200)); end
    bus.CLK_GATE_EN[9] = 1'b1;
    bus.RESET_REQ[1]   = 1'b0;
    @(negedge hclk);
    checks++; if (bus.PERIPH_CLK_EN !== ALL1 || bus.RESET_ACK[1] !== 1'b0) begin errors++; $display("FAIL unsvc_restore: got ce=%h ack1=%b expected %h 0", bus.PERIPH_CLK_EN, bus.RESET_ACK[1], ALL1); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    prev_ack = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_drop_mid();
    test_async_reset();
    test_unserviced();
    repeat (2) @(negedge hclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d outstanding acks expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
